// File: rtl/stage_decode_hs_pkg.sv
// Shared RV32 decode types: opcode map, control bundle layout and immediate formats.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RES_ALU       = 2'd0,
        RES_MEM       = 2'd1,
        RES_PC_PLUS   = 2'd2,
        RES_LUI_AUIPC = 2'd3
    } result_src_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_sel_t;

    // jal_src=1: target is PC+imm (JAL), 0: rs1+imm (JALR).
    // lui_auipc=1: AUIPC adds the PC, 0: LUI passes the immediate through.
    typedef struct packed {
        logic        regfile_wr_enable;
        result_src_t result_src;
        logic        alu_src;
        logic [1:0]  alu_op;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        jump;
        logic        jal_src;
        logic        branch;
        logic        lui_auipc;
        logic        datamem_wr_enable;
    } decode_ctrl_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_sel_t sel);
        case (sel)
            IMM_S:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_J:   imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            IMM_U:   imm_gen = {i[31:12], 12'b0};
            default: imm_gen = {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/stage_decode_hs_if.sv
// Fetch/ID/EX/WB signal bundle around the decode stage; slave is the ID stage side.
interface stage_decode_hs_if
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
);
    logic             flush;
    logic             if_valid;
    logic             if_ready;
    logic [31:0]      instr;
    logic [XLEN-1:0]  fetch_instr_addr;
    logic [XLEN-1:0]  fetch_instr_addr_plus;
    logic             id_valid;
    logic             ex_ready;
    logic             ex_load_pending;
    logic [4:0]       ex_rd;
    decode_ctrl_t     decode_ctrl;
    logic [XLEN-1:0]  decode_imm;
    logic [XLEN-1:0]  rs_data1;
    logic [XLEN-1:0]  rs_data2;
    logic [4:0]       decode_rs1;
    logic [4:0]       decode_rs2;
    logic [4:0]       decode_rd;
    logic [XLEN-1:0]  decode_instr_addr;
    logic [XLEN-1:0]  decode_instr_addr_plus;
    logic             decode_illegal;
    logic [4:0]       wb_wr_addr;
    logic [XLEN-1:0]  wb_wr_data;
    logic             wb_regfile_wr_enable;

    modport master (
        output flush, if_valid, instr, fetch_instr_addr, fetch_instr_addr_plus,
               ex_ready, ex_load_pending, ex_rd, wb_wr_addr, wb_wr_data, wb_regfile_wr_enable,
        input  if_ready, id_valid, decode_ctrl, decode_imm, rs_data1, rs_data2,
               decode_rs1, decode_rs2, decode_rd, decode_instr_addr, decode_instr_addr_plus,
               decode_illegal
    );

    modport slave (
        input  flush, if_valid, instr, fetch_instr_addr, fetch_instr_addr_plus,
               ex_ready, ex_load_pending, ex_rd, wb_wr_addr, wb_wr_data, wb_regfile_wr_enable,
        output if_ready, id_valid, decode_ctrl, decode_imm, rs_data1, rs_data2,
               decode_rs1, decode_rs2, decode_rd, decode_instr_addr, decode_instr_addr_plus,
               decode_illegal
    );
endinterface

// File: rtl/stage_decode_hs_regfile.sv
// Register file: two async read ports, one write port, optional WB->read write-through.
module decode_regfile #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0][4:0]       rd_addr,
    output logic [1:0][XLEN-1:0]  rd_data,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    output logic                  wr_commit
);
    localparam int       AW  = $clog2(NUM_REGS);
    localparam logic [5:0] NR = 6'(NUM_REGS);
    localparam bit       BYP = (BYPASS_EN != 0);

    logic [NUM_REGS-1:0][XLEN-1:0] regs;

    // Writes to x0 or past the implemented register count are dropped.
    assign wr_commit = wr_en & (wr_addr != 5'd0) & ({1'b0, wr_addr} < NR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '0;
        else if (wr_commit)
            regs[wr_addr[AW-1:0]] <= wr_data;
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic in_range;
        logic hit;
        assign in_range   = (rd_addr[p] != 5'd0) & ({1'b0, rd_addr[p]} < NR);
        assign hit        = BYP & wr_commit & (wr_addr == rd_addr[p]);
        assign rd_data[p] = !in_range ? '0 : (hit ? wr_data : regs[rd_addr[p][AW-1:0]]);
    end

endmodule

// File: rtl/stage_decode_hs.sv
// RV32 ID stage: decodes one instruction per cycle into a registered bundle, with
// valid/ready handshakes, load-use bubbles, flush and the register file.
module stage_decode_hs
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int BYPASS_EN = 1
) (
    input logic              clk,
    input logic              rst_n,
    stage_decode_hs_if.slave bus
);
    localparam bit RV32E = (NUM_REGS == 16);

    if (XLEN != 32) begin : g_xlen_chk
        $error("stage_decode_hs: only XLEN=32 is supported");
    end
    if (NUM_REGS != 32 && NUM_REGS != 16) begin : g_regs_chk
        $error("stage_decode_hs: NUM_REGS must be 16 or 32");
    end

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;

    assign instr  = bus.instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    decode_ctrl_t ctrl_d;
    imm_sel_t     imm_sel;
    logic         legal, used1, used2, used_rd;

    always_comb begin
        ctrl_d  = '0;
        imm_sel = IMM_I;
        legal   = 1'b1;
        used1   = 1'b0;
        used2   = 1'b0;
        used_rd = 1'b0;
        case (opcode)
            OP_R: begin
                {used1, used2, used_rd}  = 3'b111;
                ctrl_d.regfile_wr_enable = 1'b1;
                ctrl_d.alu_op            = 2'b10;
                ctrl_d.funct3            = funct3;
                ctrl_d.funct7b5          = instr[30];
            end
            OP_I: begin
                {used1, used_rd}         = 2'b11;
                ctrl_d.regfile_wr_enable = 1'b1;
                ctrl_d.alu_src           = 1'b1;
                ctrl_d.alu_op            = 2'b10;
                ctrl_d.funct3            = funct3;
                ctrl_d.funct7b5          = instr[30];
            end
            OP_LOAD: begin
                {used1, used_rd}         = 2'b11;
                ctrl_d.regfile_wr_enable = 1'b1;
                ctrl_d.result_src        = RES_MEM;
                ctrl_d.alu_src           = 1'b1;
                ctrl_d.funct3            = funct3;
            end
            OP_STORE: begin
                {used1, used2}           = 2'b11;
                imm_sel                  = IMM_S;
                ctrl_d.alu_src           = 1'b1;
                ctrl_d.funct3            = funct3;
                ctrl_d.datamem_wr_enable = 1'b1;
            end
            OP_BRANCH: begin
                {used1, used2}           = 2'b11;
                imm_sel                  = IMM_B;
                ctrl_d.alu_op            = 2'b01;
                ctrl_d.funct3            = funct3;
                ctrl_d.branch            = 1'b1;
            end
            OP_JAL: begin
                used_rd                  = 1'b1;
                imm_sel                  = IMM_J;
                ctrl_d.regfile_wr_enable = 1'b1;
                ctrl_d.result_src        = RES_PC_PLUS;
                ctrl_d.jump              = 1'b1;
                ctrl_d.jal_src           = 1'b1;
            end
            OP_JALR: begin
                {used1, used_rd}         = 2'b11;
                ctrl_d.regfile_wr_enable = 1'b1;
                ctrl_d.result_src        = RES_PC_PLUS;
                ctrl_d.alu_src           = 1'b1;
                ctrl_d.funct3            = funct3;
                ctrl_d.jump              = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                used_rd                  = 1'b1;
                imm_sel                  = IMM_U;
                ctrl_d.regfile_wr_enable = 1'b1;
                ctrl_d.result_src        = RES_LUI_AUIPC;
                ctrl_d.lui_auipc         = (opcode == OP_AUIPC);
            end
            default: legal = 1'b0;
        endcase
    end

    logic reg_bad, illegal;
    assign reg_bad = RV32E & ((used1 & rs1[4]) | (used2 & rs2[4]) | (used_rd & rd[4]));
    assign illegal = ~legal | reg_bad;

    logic [1:0][4:0]      rd_addr;
    logic [1:0][XLEN-1:0] rd_data;
    logic                 wr_commit;
    assign rd_addr = {rs2, rs1};

    decode_regfile #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS_EN(BYPASS_EN)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (bus.wb_regfile_wr_enable),
        .wr_addr  (bus.wb_wr_addr),
        .wr_data  (bus.wb_wr_data),
        .wr_commit(wr_commit)
    );

    logic            id_valid_q, illegal_q;
    decode_ctrl_t    ctrl_q;
    logic [XLEN-1:0] imm_q, rs_data1_q, rs_data2_q, pc_q, pc_plus_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;

    // The load-use check looks at the incoming instruction against the load now in EX.
    logic hazard, if_ready, accept, load, hit1, hit2;
    assign hazard   = bus.ex_load_pending & id_valid_q & (bus.ex_rd != 5'd0) &
                      ((used1 & (rs1 == bus.ex_rd)) | (used2 & (rs2 == bus.ex_rd)));
    assign if_ready = rst_n & (~id_valid_q | bus.ex_ready) & ~hazard;
    assign accept   = bus.if_valid & if_ready;
    assign load     = accept & ~bus.flush;
    assign hit1     = wr_commit & (bus.wb_wr_addr == rs1_q);
    assign hit2     = wr_commit & (bus.wb_wr_addr == rs2_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            ctrl_q     <= '0;
            imm_q      <= '0;
            rs_data1_q <= '0;
            rs_data2_q <= '0;
            pc_q       <= '0;
            pc_plus_q  <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else begin
            if (bus.flush) begin
                id_valid_q <= 1'b0;
                ctrl_q     <= '0;
                illegal_q  <= 1'b0;
            end else if (accept) begin
                id_valid_q <= 1'b1;
                illegal_q  <= illegal;
                ctrl_q     <= illegal ? '0 : ctrl_d;
                imm_q      <= imm_gen(instr, imm_sel);
                rs_data1_q <= rd_data[0];
                rs_data2_q <= rd_data[1];
                pc_q       <= bus.fetch_instr_addr;
                pc_plus_q  <= bus.fetch_instr_addr_plus;
                rs1_q      <= rs1;
                rs2_q      <= rs2;
                rd_q       <= rd;
            end else if (id_valid_q & bus.ex_ready) begin
                id_valid_q <= 1'b0;
                if (hazard) begin
                    ctrl_q    <= '0;
                    illegal_q <= 1'b0;
                end
            end
            // A held bundle keeps its operands current with writeback.
            if (!load && hit1) rs_data1_q <= bus.wb_wr_data;
            if (!load && hit2) rs_data2_q <= bus.wb_wr_data;
        end
    end

    assign bus.if_ready               = if_ready;
    assign bus.id_valid               = id_valid_q;
    assign bus.decode_ctrl            = ctrl_q;
    assign bus.decode_imm             = imm_q;
    assign bus.rs_data1               = rs_data1_q;
    assign bus.rs_data2               = rs_data2_q;
    assign bus.decode_rs1             = rs1_q;
    assign bus.decode_rs2             = rs2_q;
    assign bus.decode_rd              = rd_q;
    assign bus.decode_instr_addr      = pc_q;
    assign bus.decode_instr_addr_plus = pc_plus_q;
    assign bus.decode_illegal         = illegal_q;

endmodule

// File: tb/tb_stage_decode_hs.sv
// Directed bench: three ID stages (RV32I+bypass, RV32I no bypass, RV32E) share one stimulus.
module tb_stage_decode_hs;
    import riscv_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        flush = 0, if_valid = 0, ex_ready = 0, ex_load_pending = 0, wb_en = 0;
    logic [31:0] instr = 0, pc = 0, pcp = 0, wb_data = 0;
    logic [4:0]  ex_rd = 0, wb_addr = 0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gd
        localparam int NR = (g == 2) ? 16 : 32;
        localparam int BY = (g == 1) ? 0 : 1;
        stage_decode_hs_if #(.XLEN(32)) bus ();
        assign bus.flush                 = flush;
        assign bus.if_valid              = if_valid;
        assign bus.instr                 = instr;
        assign bus.fetch_instr_addr      = pc;
        assign bus.fetch_instr_addr_plus = pcp;
        assign bus.ex_ready              = ex_ready;
        assign bus.ex_load_pending       = ex_load_pending;
        assign bus.ex_rd                 = ex_rd;
        assign bus.wb_wr_addr            = wb_addr;
        assign bus.wb_wr_data            = wb_data;
        assign bus.wb_regfile_wr_enable  = wb_en;
        stage_decode_hs #(.XLEN(32), .NUM_REGS(NR), .BYPASS_EN(BY)) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus)
        );
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (gd[0].bus.if_ready !== 1'b0) begin errors++; $display("FAIL rst_if_ready got %0h want 0", gd[0].bus.if_ready); end
        checks++; if (gd[0].bus.id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid got %0h want 0", gd[0].bus.id_valid); end
        checks++; if (gd[0].bus.decode_ctrl !== '0) begin errors++; $display("FAIL rst_ctrl got %0h want 0", gd[0].bus.decode_ctrl); end
        tick; tick;
        rst_n = 1'b1;
        #1;
        checks++; if (gd[0].bus.if_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0h want 1", gd[0].bus.if_ready); end
    endtask

    task automatic test_addi;
        ex_ready = 1; if_valid = 1; instr = 32'hFFF00293; pc = 32'h100; pcp = 32'h104;
        tick;
        if_valid = 0;
        checks++; if (gd[0].bus.id_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0h want 1", gd[0].bus.id_valid); end
        checks++; if (gd[0].bus.decode_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm got %0h want ffffffff", gd[0].bus.decode_imm); end
        checks++; if (gd[0].bus.decode_ctrl.alu_src !== 1'b1) begin errors++; $display("FAIL addi_alu_src got %0h want 1", gd[0].bus.decode_ctrl.alu_src); end
        checks++; if (gd[0].bus.decode_ctrl.alu_op !== 2'b10) begin errors++; $display("FAIL addi_alu_op got %0h want 2", gd[0].bus.decode_ctrl.alu_op); end
        checks++; if (gd[0].bus.decode_rd !== 5'd5) begin errors++; $display("FAIL addi_rd got %0d want 5", gd[0].bus.decode_rd); end
        checks++; if (gd[0].bus.decode_instr_addr_plus !== 32'h104) begin errors++; $display("FAIL addi_pc_plus got %0h want 104", gd[0].bus.decode_instr_addr_plus); end
        tick;
        checks++; if (gd[0].bus.id_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0h want 0", gd[0].bus.id_valid); end
    endtask

    task automatic test_back_to_back;
        if_valid = 1; instr = 32'h123450B7;   // lui x1,0x12345
        tick;
        instr = 32'hFE20AE23;                 // sw x2,-4(x1)
        checks++; if (gd[0].bus.decode_imm !== 32'h1234_5000) begin errors++; $display("FAIL lui_imm got %0h want 12345000", gd[0].bus.decode_imm); end
        checks++; if (gd[0].bus.decode_ctrl.result_src !== RES_LUI_AUIPC) begin errors++; $display("FAIL lui_src got %0h want 3", gd[0].bus.decode_ctrl.result_src); end
        tick;
        instr = 32'hFE000CE3;                 // beq x0,x0,-8
        checks++; if (gd[0].bus.decode_imm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL sw_imm got %0h want fffffffc", gd[0].bus.decode_imm); end
        checks++; if (gd[0].bus.decode_ctrl.datamem_wr_enable !== 1'b1 || gd[0].bus.decode_ctrl.regfile_wr_enable !== 1'b0) begin errors++; $display("FAIL sw_ctrl got %0h want dmem=1 rf=0", gd[0].bus.decode_ctrl); end
        tick;
        if_valid = 0;
        checks++; if (gd[0].bus.decode_imm !== 32'hFFFF_FFF8) begin errors++; $display("FAIL beq_imm got %0h want fffffff8", gd[0].bus.decode_imm); end
        checks++; if (gd[0].bus.decode_ctrl.alu_op !== 2'b01 || gd[0].bus.decode_ctrl.branch !== 1'b1) begin errors++; $display("FAIL beq_ctrl got %0h want alu_op=1 branch=1", gd[0].bus.decode_ctrl); end
        checks++; if (gd[0].bus.id_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0h want 1", gd[0].bus.id_valid); end
        tick;
    endtask

    task automatic test_load_use;
        if_valid = 1; instr = 32'hFFF00293;
        tick;
        ex_load_pending = 1; ex_rd = 7; instr = 32'h00138433;  // add x8,x7,x1
        #1;
        checks++; if (gd[0].bus.if_ready !== 1'b0) begin errors++; $display("FAIL lu_rs1_ready got %0h want 0", gd[0].bus.if_ready); end
        tick;
        checks++; if (gd[0].bus.id_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %0h want 0", gd[0].bus.id_valid); end
        checks++; if (gd[0].bus.decode_ctrl !== '0) begin errors++; $display("FAIL bubble_ctrl got %0h want 0", gd[0].bus.decode_ctrl); end
        ex_load_pending = 0;
        #1;
        checks++; if (gd[0].bus.if_ready !== 1'b1) begin errors++; $display("FAIL lu_release_ready got %0h want 1", gd[0].bus.if_ready); end
        tick;
        checks++; if (gd[0].bus.id_valid !== 1'b1 || gd[0].bus.decode_rd !== 5'd8 || gd[0].bus.decode_rs1 !== 5'd7) begin errors++; $display("FAIL lu_accept got valid=%0h rd=%0d rs1=%0d want 1 8 7", gd[0].bus.id_valid, gd[0].bus.decode_rd, gd[0].bus.decode_rs1); end
        ex_load_pending = 1; ex_rd = 1;
        #1;
        checks++; if (gd[0].bus.if_ready !== 1'b0) begin errors++; $display("FAIL lu_rs2_ready got %0h want 0", gd[0].bus.if_ready); end
        ex_rd = 0; instr = 32'hFFF00293;
        #1;
        checks++; if (gd[0].bus.if_ready !== 1'b1) begin errors++; $display("FAIL lu_x0_ready got %0h want 1", gd[0].bus.if_ready); end
        ex_load_pending = 0; if_valid = 0;
        tick;
    endtask

    task automatic test_hold;
        if_valid = 1; instr = 32'h00518313; pc = 32'h200; pcp = 32'h204;  // addi x6,x3,5
        tick;
        ex_ready = 0; instr = 32'h00138433; wb_en = 1; wb_addr = 3; wb_data = 32'hCAFE;
        #1;
        checks++; if (gd[0].bus.if_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got %0h want 0", gd[0].bus.if_ready); end
        tick;
        wb_addr = 7; wb_data = 32'hBAD;
        tick;
        wb_en = 0;
        tick;
        checks++; if (gd[0].bus.rs_data1 !== 32'hCAFE) begin errors++; $display("FAIL hold_rs1 got %0h want cafe", gd[0].bus.rs_data1); end
        checks++; if (gd[0].bus.rs_data2 !== 32'h0) begin errors++; $display("FAIL hold_rs2 got %0h want 0", gd[0].bus.rs_data2); end
        checks++; if (gd[0].bus.id_valid !== 1'b1 || gd[0].bus.decode_rd !== 5'd6 || gd[0].bus.decode_imm !== 32'h5) begin errors++; $display("FAIL hold_bundle got valid=%0h rd=%0d imm=%0h want 1 6 5", gd[0].bus.id_valid, gd[0].bus.decode_rd, gd[0].bus.decode_imm); end
        checks++; if (gd[0].bus.decode_instr_addr !== 32'h200 || gd[0].bus.decode_ctrl.alu_src !== 1'b1) begin errors++; $display("FAIL hold_pc got %0h want 200", gd[0].bus.decode_instr_addr); end
        ex_ready = 1; if_valid = 0;
        tick;
    endtask

    task automatic test_bypass;
        wb_en = 1; wb_addr = 9; wb_data = 32'h5555;
        tick;
        if_valid = 1; instr = 32'h40948133; wb_data = 32'h1234;  // sub x2,x9,x9
        tick;
        wb_en = 0; if_valid = 0;
        checks++; if (gd[0].bus.rs_data1 !== 32'h1234 || gd[0].bus.rs_data2 !== 32'h1234) begin errors++; $display("FAIL byp_on got %0h/%0h want 1234", gd[0].bus.rs_data1, gd[0].bus.rs_data2); end
        checks++; if (gd[1].bus.rs_data1 !== 32'h5555 || gd[1].bus.rs_data2 !== 32'h5555) begin errors++; $display("FAIL byp_off got %0h/%0h want 5555", gd[1].bus.rs_data1, gd[1].bus.rs_data2); end
        checks++; if (gd[2].bus.rs_data1 !== 32'h1234) begin errors++; $display("FAIL byp_e got %0h want 1234", gd[2].bus.rs_data1); end
        checks++; if (gd[0].bus.decode_ctrl.funct7b5 !== 1'b1) begin errors++; $display("FAIL sub_f7 got %0h want 1", gd[0].bus.decode_ctrl.funct7b5); end
        tick;
    endtask

    task automatic test_illegal;
        if_valid = 1; instr = 32'h002088B3;  // add x17,x1,x2
        tick;
        instr = 32'h0000007F;
        checks++; if (gd[2].bus.decode_illegal !== 1'b1 || gd[2].bus.decode_ctrl !== '0 || gd[2].bus.id_valid !== 1'b1) begin errors++; $display("FAIL ill_e got ill=%0h ctrl=%0h valid=%0h want 1 0 1", gd[2].bus.decode_illegal, gd[2].bus.decode_ctrl, gd[2].bus.id_valid); end
        checks++; if (gd[0].bus.decode_illegal !== 1'b0 || gd[0].bus.decode_ctrl.regfile_wr_enable !== 1'b1) begin errors++; $display("FAIL ill_i_legal got ill=%0h want 0", gd[0].bus.decode_illegal); end
        tick;
        if_valid = 0;
        checks++; if (gd[0].bus.decode_illegal !== 1'b1 || gd[0].bus.decode_ctrl !== '0 || gd[0].bus.id_valid !== 1'b1) begin errors++; $display("FAIL ill_op got ill=%0h ctrl=%0h valid=%0h want 1 0 1", gd[0].bus.decode_illegal, gd[0].bus.decode_ctrl, gd[0].bus.id_valid); end
        tick;
    endtask

    task automatic test_flush;
        if_valid = 1; instr = 32'hFFF00293; flush = 1; wb_en = 1; wb_addr = 4; wb_data = 32'h4444;
        tick;
        flush = 0; wb_en = 0; if_valid = 0;
        checks++; if (gd[0].bus.id_valid !== 1'b0 || gd[0].bus.decode_ctrl !== '0 || gd[0].bus.decode_illegal !== 1'b0) begin errors++; $display("FAIL flush_acc got valid=%0h ctrl=%0h ill=%0h want 0 0 0", gd[0].bus.id_valid, gd[0].bus.decode_ctrl, gd[0].bus.decode_illegal); end
        if_valid = 1; instr = 32'h00020533;  // add x10,x4,x0
        tick;
        if_valid = 0;
        checks++; if (gd[0].bus.id_valid !== 1'b1 || gd[0].bus.rs_data1 !== 32'h4444) begin errors++; $display("FAIL flush_wb got valid=%0h rs1=%0h want 1 4444", gd[0].bus.id_valid, gd[0].bus.rs_data1); end
        ex_ready = 0; flush = 1;
        tick;
        flush = 0; ex_ready = 1;
        checks++; if (gd[0].bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_hold got %0h want 0", gd[0].bus.id_valid); end
    endtask

    task automatic test_async_reset;
        if_valid = 1; instr = 32'h00020533;
        tick;
        ex_ready = 0; if_valid = 0;
        tick;
        checks++; if (gd[0].bus.id_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got %0h want 1", gd[0].bus.id_valid); end
        #3 rst_n = 0;
        #1;
        checks++; if (gd[0].bus.id_valid !== 1'b0 || gd[0].bus.if_ready !== 1'b0) begin errors++; $display("FAIL arst_hs got valid=%0h ready=%0h want 0 0", gd[0].bus.id_valid, gd[0].bus.if_ready); end
        checks++; if (gd[0].bus.rs_data1 !== '0 || gd[0].bus.decode_rd !== '0 || gd[0].bus.decode_rs1 !== '0 || gd[0].bus.decode_instr_addr_plus !== '0) begin errors++; $display("FAIL arst_out got rs1=%0h rd=%0d want 0", gd[0].bus.rs_data1, gd[0].bus.decode_rd); end
        rst_n = 1; ex_ready = 1;
        tick;
        if_valid = 1;
        tick;
        if_valid = 0;
        checks++; if (gd[0].bus.id_valid !== 1'b1 || gd[0].bus.rs_data1 !== 32'h0) begin errors++; $display("FAIL arst_rf got valid=%0h rs1=%0h want 1 0", gd[0].bus.id_valid, gd[0].bus.rs_data1); end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_back_to_back;
        test_load_use;
        test_hold;
        test_bypass;
        test_illegal;
        test_flush;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
